multiexp_rd_arbiter: RTL

Two-to-one AXI4 read-channel arbiter for the multiexp kernels. The scalar and point read masters share a single AXI4 memory read port through this block. Address requests are granted round-robin, and the order of grants is recorded in an in-order tag FIFO. Read-data beats are returned to whichever requester owns the oldest outstanding burst. The block sits between the two `*_axi_read_master` instances and the kernel's memory-facing `m_axi` read port.

---
 rtl/multiexp_rd_arbiter.sv | 86 ++++++++
 1 files changed

// File: rtl/multiexp_rd_arbiter.sv
// multiexp_rd_arbiter: round-robin 2:1 AXI4 read arbiter with in-order tag FIFO for R routing
module multiexp_rd_arbiter #(
  parameter int ADDR_WIDTH      = 64,
  parameter int DATA_WIDTH      = 512,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               s0_arvalid,
  output logic                               s0_arready,
  input  logic [ADDR_WIDTH-1:0]              s0_araddr,
  input  logic [7:0]                         s0_arlen,
  output logic                               s0_rvalid,
  input  logic                               s0_rready,
  output logic [DATA_WIDTH-1:0]              s0_rdata,
  output logic                               s0_rlast,
  input  logic                               s1_arvalid,
  output logic                               s1_arready,
  input  logic [ADDR_WIDTH-1:0]              s1_araddr,
  input  logic [7:0]                         s1_arlen,
  output logic                               s1_rvalid,
  input  logic                               s1_rready,
  output logic [DATA_WIDTH-1:0]              s1_rdata,
  output logic                               s1_rlast,
  output logic                               m_arvalid,
  input  logic                               m_arready,
  output logic [ADDR_WIDTH-1:0]              m_araddr,
  output logic [7:0]                         m_arlen,
  input  logic                               m_rvalid,
  output logic                               m_rready,
  input  logic [DATA_WIDTH-1:0]              m_rdata,
  input  logic                               m_rlast,
  output logic [$clog2(MAX_OUTSTANDING):0]   o_outstanding
);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t state, state_nx;
  logic last_grant, g, grant, ne, head, pop;
  logic [PW:0] count;
  logic [PW-1:0] wptr, rptr;
  logic [MAX_OUTSTANDING-1:0] tags;
  // grant decision and AR next state; full is the count MSB since depth is a power of two
  always_comb begin
    grant = state == IDLE && !count[PW] && (s0_arvalid || s1_arvalid);
    g = (s0_arvalid && s1_arvalid) ? ~last_grant : s1_arvalid;
    state_nx = state == IDLE ? (grant ? ISSUE : IDLE) : (m_arready ? IDLE : ISSUE);
  end
  assign s0_arready = grant & ~g;
  assign s1_arready = grant & g;
  assign m_arvalid = state == ISSUE;
  assign ne = count != '0;
  assign head = tags[rptr];
  assign s0_rvalid = m_rvalid & ne & ~head;
  assign s1_rvalid = m_rvalid & ne & head;
  assign m_rready = ne & (head ? s1_rready : s0_rready);
  assign s0_rdata = m_rdata;
  assign s1_rdata = m_rdata;
  assign s0_rlast = m_rlast;
  assign s1_rlast = m_rlast;
  assign pop = m_rvalid & m_rready & m_rlast;
  assign o_outstanding = count;
  // AR state, output address register, FIFO pointers and occupancy
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      last_grant <= 1'b1;
      m_araddr <= '0;
      m_arlen <= '0;
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      state <= state_nx;
      if (grant) begin
        last_grant <= g;
        m_araddr <= g ? s1_araddr : s0_araddr;
        m_arlen <= g ? s1_arlen : s0_arlen;
        wptr <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      count <= count + (PW+1)'(grant) - (PW+1)'(pop);
    end
  end
  // tag storage needs no reset; occupancy alone decides validity
  always_ff @(posedge i_clk) if (grant) tags[wptr] <= g;
endmodule
